uart_rx_oversample: RTL and testbench
=====================================

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8: data bits per frame.
REQ-002 SHALL have parameter OVER_SAMPLE, default 16: sample ticks per bit.
REQ-003 SHALL have parameter MID_SAMPLE, default 8: tick index used to sample the start bit.
REQ-004 SHALL have parameter DIV_SAMPLE, default 326: i_clk cycles per sample tick (50 MHz / (9600 x 16)).
REQ-005 SHALL have port i_clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_rx_en, input, 1: receiver enable.
REQ-008 SHALL have port i_rx, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port o_data, output, SIZE_DATA: last correctly received byte.
REQ-010 SHALL have port o_rx_done, output, 1: one-cycle pulse when o_data updates.
REQ-011 SHALL have port o_frame_err, output, 1: one-cycle pulse when the stop bit is bad.
REQ-012 SHALL have port o_busy, output, 1: high in any state except IDLE.

Function
REQ-013 SHALL pass i_rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s, so line-to-decision latency is 2 cycles.
REQ-014 SHALL generate a sample tick every DIV_SAMPLE cycles while not in IDLE; the divider and tick counter clear on IDLE exit, so the first tick comes DIV_SAMPLE cycles after start detection.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: if i_rx_en=1 and rx_s=0, SHALL go to START with tick counter=0.
REQ-017 START: on the tick where the counter reaches MID_SAMPLE-1, SHALL go to DATA (counter=0) if rx_s=0; otherwise (glitch) SHALL go to IDLE with no output pulse.
REQ-018 DATA: on the tick where the counter reaches OVER_SAMPLE-1, SHALL shift rx_s into the shift register LSB-first, clear the counter, and increment the bit counter.
REQ-019 DATA: after bit SIZE_DATA-1 is sampled, SHALL go to STOP.
REQ-020 STOP: on the tick where the counter reaches OVER_SAMPLE-1, if rx_s=1, SHALL load o_data from the shift register and pulse o_rx_done for exactly 1 cycle.
REQ-021 STOP: if rx_s=0 at that sample, SHALL pulse o_frame_err for 1 cycle and leave o_data unchanged.
REQ-022 After either STOP outcome, SHALL return to IDLE in the same cycle.
REQ-023 o_rx_done and o_frame_err SHALL never be high together.
REQ-024 o_data SHALL hold its value between frames.
REQ-025 i_rx_en=0 in any non-IDLE state SHALL force IDLE on the next edge: frame aborted, no pulse, o_data unchanged.
REQ-026 A start edge arriving in the IDLE cycle just after STOP SHALL be accepted, so back-to-back frames are supported.
REQ-027 Tick counter SHALL be ceil(log2(OVER_SAMPLE)) bits; bit counter ceil(log2(SIZE_DATA+1)) bits; no counter may wrap unintentionally.

Reset
REQ-028 i_rst_n=0 SHALL immediately force: state=IDLE, all counters=0, shift register=0, o_data=0, o_rx_done=0, o_frame_err=0, o_busy=0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, reception resumes only on a new falling edge.

Verification (DIV_SAMPLE=4, OVER_SAMPLE=16, MID_SAMPLE=8, bit period 64 clocks)
REQ-030 Send frame 0xA5 (start 0, bits LSB-first, stop 1) with i_rx_en=1 -> o_data=0xA5, one o_rx_done pulse, o_frame_err stays 0.
REQ-031 Drive a 20-clock low glitch on i_rx -> FSM returns to IDLE, no pulses, o_data unchanged.
REQ-032 Send 0x3C with stop bit=0 -> one o_frame_err pulse, o_data keeps its prior value 0xA5.
REQ-033 Send 0x00 then 0xFF with no idle gap -> two o_rx_done pulses, o_data=0x00 then 0xFF.
REQ-034 Drop i_rx_en during bit 3 of 0x55 -> o_busy falls next cycle, no pulse; next frame 0x55 with enable high is received correctly.
REQ-035 Assert i_rst_n=0 during the DATA state -> all outputs 0 asynchronously; after release, frame 0x81 is received as 0x81.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 2-flop line synchronizer, sample-tick divider and
// start/data/stop FSM that samples mid-bit and flags bad stop bits.
module uart_rx_oversample #(
    parameter int unsigned SIZE_DATA   = 8,
    parameter int unsigned OVER_SAMPLE = 16,
    parameter int unsigned MID_SAMPLE  = 8,
    parameter int unsigned DIV_SAMPLE  = 326
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_en,
    input  logic                 i_rx,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned TW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
    localparam int unsigned BW = $clog2(SIZE_DATA + 1);
    localparam int unsigned DW = (DIV_SAMPLE > 1) ? $clog2(DIV_SAMPLE) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(MID_SAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVER_SAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE_DATA - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV_SAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [DW-1:0]        div_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [SIZE_DATA-1:0] shift_q;
    logic                 tick;

    // Synchronizer resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick = (state_q != StIdle) && (div_q == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q <= '0;
        end else if (state_q == StIdle || !i_rx_en || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            if (state_q != StIdle && !i_rx_en) begin
                state_q <= StIdle;
                tick_q  <= '0;
                bit_q   <= '0;
                o_busy  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (i_rx_en && !rx_s_q) begin
                            state_q <= StStart;
                            tick_q  <= '0;
                            bit_q   <= '0;
                            o_busy  <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (tick) begin
                            if (tick_q == TICK_MID) begin
                                tick_q <= '0;
                                if (!rx_s_q) begin
                                    state_q <= StData;
                                end else begin
                                    state_q <= StIdle;
                                    o_busy  <= 1'b0;
                                end
                            end else begin
                                tick_q <= tick_q + 1'b1;
                            end
                        end
                    end
                    StData: begin
                        if (tick) begin
                            if (tick_q == TICK_LAST) begin
                                tick_q  <= '0;
                                shift_q <= {rx_s_q, shift_q[SIZE_DATA-1:1]};
                                bit_q   <= bit_q + 1'b1;
                                if (bit_q == BIT_LAST) begin
                                    state_q <= StStop;
                                end
                            end else begin
                                tick_q <= tick_q + 1'b1;
                            end
                        end
                    end
                    StStop: begin
                        if (tick) begin
                            if (tick_q == TICK_LAST) begin
                                tick_q  <= '0;
                                bit_q   <= '0;
                                state_q <= StIdle;
                                o_busy  <= 1'b0;
                                if (rx_s_q) begin
                                    o_data    <= shift_q;
                                    o_rx_done <= 1'b1;
                                end else begin
                                    o_frame_err <= 1'b1;
                                end
                            end else begin
                                tick_q <= tick_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench: frames are serialised from byte/stop-bit values and every
// expected pulse and data value comes from an event queue built from those frames.
module tb_uart_rx_oversample;

    localparam int unsigned BIT_CLKS = 64;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_rx_en;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_busy;

    int checks;
    int failures;

    typedef struct {
        logic       good;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    logic [7:0] exp_data;

    uart_rx_oversample #(
        .SIZE_DATA  (8),
        .OVER_SAMPLE(16),
        .MID_SAMPLE (8),
        .DIV_SAMPLE (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rx_en    (i_rx_en),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        i_rx = v;
        wait_clk(n);
    endtask

    // Every pulse must match the oldest outstanding frame outcome.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            exp_data = 8'h00;
        end else if (o_rx_done && o_frame_err) begin
            check_eq("pulse_exclusive", 32'd1, 32'd0);
        end else if (o_rx_done || o_frame_err) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, o_rx_done, o_frame_err}, 32'd0);
            end else begin
                mon_ev = exp_q.pop_front();
                check_eq("pulse_kind", o_rx_done, mon_ev.good);
                if (mon_ev.good) exp_data = mon_ev.data;
                check_eq("o_data_at_pulse", o_data, exp_data);
            end
        end
    end

    // mode 0: normal frame, 1: drop enable mid abort_bit, 2: reset mid abort_bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit,
                              input int mode, input int gap);
        ev_t e;
        if (mode == 0) begin
            e.good = stop;
            e.data = d;
            exp_q.push_back(e);
        end
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (mode != 0 && i == abort_bit) begin
                i_rx = d[i];
                wait_clk(32);
                @(negedge i_clk);
                check_eq("busy_before_abort", o_busy, 1);
                @(posedge i_clk);
                #1;
                if (mode == 1) begin
                    i_rx_en = 1'b0;
                    @(posedge i_clk);
                    @(negedge i_clk);
                    check_eq("busy_after_en_drop", o_busy, 0);
                end else begin
                    #2 i_rst_n = 1'b0;
                    #1;
                    check_eq("rst_data", o_data, 0);
                    check_eq("rst_done", o_rx_done, 0);
                    check_eq("rst_err", o_frame_err, 0);
                    check_eq("rst_busy", o_busy, 0);
                end
                wait_clk(28);
            end else begin
                drive_bit(d[i], BIT_CLKS);
            end
        end
        drive_bit(stop, BIT_CLKS);
        i_rx = 1'b1;
        if (mode == 1) i_rx_en = 1'b1;
        if (mode == 2) i_rst_n = 1'b1;
        wait_clk(gap);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge i_clk);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_data"}, o_data, exp_data);
        check_eq({tag, "_busy"}, o_busy, 0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        logic       s;
        checks   = 0;
        failures = 0;
        exp_data = 8'h00;
        i_rst_n  = 1'b0;
        i_rx_en  = 1'b1;
        i_rx     = 1'b1;
        wait_clk(3);
        @(negedge i_clk);
        check_eq("reset_data", o_data, 0);
        check_eq("reset_done", o_rx_done, 0);
        check_eq("reset_err", o_frame_err, 0);
        check_eq("reset_busy", o_busy, 0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        wait_clk(10);

        send_frame(8'hA5, 1'b1, -1, 0, 20);
        expect_idle("frame_a5");

        // Short low glitch: start bit rejected at mid-sample.
        i_rx = 1'b0;
        wait_clk(10);
        @(negedge i_clk);
        check_eq("glitch_busy", o_busy, 1);
        wait_clk(10);
        i_rx = 1'b1;
        wait_clk(60);
        expect_idle("glitch");

        send_frame(8'h3C, 1'b0, -1, 0, 100);
        expect_idle("frame_err");
        check_eq("data_kept_a5", o_data, 8'hA5);

        send_frame(8'h00, 1'b1, -1, 0, 0);
        send_frame(8'hFF, 1'b1, -1, 0, 20);
        expect_idle("back_to_back");

        send_frame(8'h55, 1'b1, 3, 1, 20);
        expect_idle("en_abort");
        send_frame(8'h55, 1'b1, -1, 0, 20);
        expect_idle("after_abort");

        send_frame(8'h6E, 1'b1, 2, 2, 20);
        expect_idle("rst_abort");
        send_frame(8'h81, 1'b1, -1, 0, 20);
        expect_idle("after_reset");
        check_eq("data_81", o_data, 8'h81);

        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, s, -1, 0, s ? int'($urandom_range(0, 40)) : 100);
        end
        wait_clk(20);
        expect_idle("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
